// File: rtl/out_sched_pkg.sv
// Shared types and defaults for the two-source output stream scheduler.
package out_sched_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int LEN_W_DEF  = 16;
   localparam int CNT_W_DEF  = 12;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARB  = 2'd1,
      ST_XFER = 2'd2
   } state_e;

   localparam logic SRC0 = 1'b0;
   localparam logic SRC1 = 1'b1;

endpackage

// File: rtl/out_rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the last source that finished a packet.
module out_rr_arb2
   import out_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] valid,
   input  logic       pkt_done,
   input  logic       done_src,
   output logic       gnt_vld,
   output logic       gnt_src
);

   logic rr_last;

   // Pointer starts at source 1 so source 0 wins the first contested arbitration.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last <= SRC1;
      end else if (pkt_done) begin
         rr_last <= done_src;
      end
   end

   always_comb begin
      gnt_vld = |valid;
      gnt_src = SRC0;
      if (valid[0] && valid[1]) begin
         gnt_src = ~rr_last;
      end else if (valid[1]) begin
         gnt_src = SRC1;
      end
   end

endmodule

// File: rtl/out_stream_scheduler.sv
// Packet-level scheduler sharing one AXI-Stream output between two sources.
//   state   | meaning
//   IDLE    | waiting for i_start; config latched on start
//   ARB     | pick the next source (round robin), one cycle minimum
//   XFER    | pass-through of the granted source until its last beat
module out_stream_scheduler
   import out_sched_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int LEN_W  = LEN_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_pkt_beats,
   input  logic [CNT_W-1:0]  i_num_pkts,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic              s0_tvalid,
   output logic              s0_tready,
   input  logic [DATA_W-1:0] s1_tdata,
   input  logic              s1_tvalid,
   output logic              s1_tready,
   output logic [DATA_W-1:0] m_tdata,
   output logic              m_tvalid,
   input  logic              m_tready,
   output logic              m_tlast,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_grant
);

   state_e             state_q, state_d;
   logic               grant_q;
   logic               done_q;
   logic [LEN_W-1:0]   pkt_beats_q, beat_cnt_q;
   logic [CNT_W-1:0]   num_pkts_q, pkt_cnt_q;
   logic               arb_vld, arb_src;
   logic               cfg_zero, beat_hs, last_beat, last_pkt, pkt_done;

   assign cfg_zero  = (i_pkt_beats == '0) || (i_num_pkts == '0);
   assign last_beat = (beat_cnt_q == pkt_beats_q - LEN_W'(1));
   assign last_pkt  = (pkt_cnt_q == num_pkts_q - CNT_W'(1));
   assign beat_hs   = m_tvalid & m_tready;
   assign pkt_done  = beat_hs & last_beat;

   out_rr_arb2 u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .valid    ({s1_tvalid, s0_tvalid}),
      .pkt_done (pkt_done),
      .done_src (grant_q),
      .gnt_vld  (arb_vld),
      .gnt_src  (arb_src)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (i_start && !cfg_zero) state_d = ST_ARB;
         ST_ARB:  if (arb_vld) state_d = ST_XFER;
         ST_XFER: if (pkt_done) state_d = last_pkt ? ST_IDLE : ST_ARB;
         default: state_d = ST_IDLE;
      endcase
   end

   // Grant is locked for the packet: a source dropping tvalid just stalls the output.
   always_comb begin
      m_tvalid  = 1'b0;
      m_tdata   = '0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
      if (state_q == ST_XFER) begin
         if (grant_q == SRC1) begin
            m_tvalid  = s1_tvalid;
            m_tdata   = s1_tdata;
            s1_tready = m_tready;
         end else begin
            m_tvalid  = s0_tvalid;
            m_tdata   = s0_tdata;
            s0_tready = m_tready;
         end
      end
   end

   assign m_tlast = m_tvalid & last_beat;
   assign o_busy  = (state_q != ST_IDLE);
   assign o_done  = done_q;
   assign o_grant = grant_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_q     <= SRC0;
         done_q      <= 1'b0;
         pkt_beats_q <= '0;
         num_pkts_q  <= '0;
         beat_cnt_q  <= '0;
         pkt_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  pkt_beats_q <= i_pkt_beats;
                  num_pkts_q  <= i_num_pkts;
                  beat_cnt_q  <= '0;
                  pkt_cnt_q   <= '0;
                  done_q      <= cfg_zero;
               end
            end
            ST_ARB: begin
               if (arb_vld) grant_q <= arb_src;
            end
            ST_XFER: begin
               if (beat_hs) begin
                  if (last_beat) begin
                     beat_cnt_q <= '0;
                     pkt_cnt_q  <= pkt_cnt_q + CNT_W'(1);
                     done_q     <= last_pkt;
                  end else begin
                     beat_cnt_q <= beat_cnt_q + LEN_W'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_out_stream_scheduler.sv
// Self-checking bench: cycle table, directed corner sequences and randomized runs vs. a packet-level model.
module tb_out_stream_scheduler;
   localparam int DATA_W = 64;
   localparam int LEN_W  = 16;
   localparam int CNT_W  = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              i_start;
   logic [LEN_W-1:0]  i_pkt_beats;
   logic [CNT_W-1:0]  i_num_pkts;
   logic [DATA_W-1:0] s0_tdata, s1_tdata, m_tdata;
   logic              s0_tvalid, s1_tvalid, s0_tready, s1_tready;
   logic              m_tvalid, m_tready, m_tlast;
   logic              o_busy, o_done, o_grant;

   always #5 clk = ~clk;

   out_stream_scheduler #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_pkt_beats(i_pkt_beats),
      .i_num_pkts(i_num_pkts), .s0_tdata(s0_tdata), .s0_tvalid(s0_tvalid),
      .s0_tready(s0_tready), .s1_tdata(s1_tdata), .s1_tvalid(s1_tvalid),
      .s1_tready(s1_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
      .m_tready(m_tready), .m_tlast(m_tlast), .o_busy(o_busy), .o_done(o_done),
      .o_grant(o_grant)
   );

   int checks = 0;
   int errors = 0;

   logic             v0, v1, rdy, start;
   logic [LEN_W-1:0] cfg_beats;
   logic [CNT_W-1:0] cfg_pkts;
   int unsigned      cnt0, cnt1;
   int unsigned      exp_cnt[2];
   int               exp_beats, beat_in_pkt, cur_src, beats_total, done_count;
   int               pkt_src[$];
   logic             alt_mode;
   logic             prev_stall, prev_last;
   logic [63:0]      prev_data;

   typedef struct {
      logic v0, v1, rdy, start;
      logic tvalid, tlast, s0r, s1r, busy, done, grant;
   } vec_t;
   vec_t tv[13];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [63:0] word(input int src, input int unsigned n);
      return {(src == 0) ? 32'hA000_0000 : 32'hB000_0000, n};
   endfunction

   // One clock: drive at negedge, sample settled outputs 1ns later, update the packet model.
   task automatic step();
      logic hs0, hs1, mhs;
      int   src;
      @(negedge clk);
      s0_tdata = word(0, cnt0);
      s1_tdata = word(1, cnt1);
      s0_tvalid = v0; s1_tvalid = v1; m_tready = rdy; i_start = start;
      i_pkt_beats = cfg_beats; i_num_pkts = cfg_pkts;
      #1;
      hs0 = s0_tvalid & s0_tready;
      hs1 = s1_tvalid & s1_tready;
      mhs = m_tvalid & m_tready;
      chk("both_ready", {63'd0, s0_tready & s1_tready}, 64'd0);
      if (prev_stall && m_tvalid) begin
         chk("stall_data", m_tdata, prev_data);
         chk("stall_last", {63'd0, m_tlast}, {63'd0, prev_last});
      end
      prev_stall = m_tvalid & !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      if (o_done) done_count++;
      if (mhs) begin
         if (beat_in_pkt == 0) begin
            src = (m_tdata[63:32] == 32'hB000_0000) ? 1 : 0;
            if (alt_mode) chk("rr_order", src, pkt_src.size() % 2);
            pkt_src.push_back(src);
            cur_src = src;
         end
         chk("data", m_tdata, word(cur_src, exp_cnt[cur_src]));
         chk("grant", {63'd0, o_grant}, cur_src);
         chk("src_hs", {62'd0, hs1, hs0}, (cur_src == 1) ? 2 : 1);
         chk("tlast", {63'd0, m_tlast}, (beat_in_pkt == exp_beats - 1) ? 1 : 0);
         exp_cnt[cur_src]++;
         beats_total++;
         beat_in_pkt = (beat_in_pkt == exp_beats - 1) ? 0 : beat_in_pkt + 1;
      end else begin
         chk("stray_hs", {62'd0, hs1, hs0}, 0);
      end
      if (hs0) cnt0++;
      if (hs1) cnt1++;
   endtask

   task automatic clear_model();
      cnt0 = 0; cnt1 = 0; exp_cnt[0] = 0; exp_cnt[1] = 0;
      beat_in_pkt = 0; beats_total = 0; done_count = 0;
      pkt_src.delete();
      alt_mode = 1'b0; prev_stall = 1'b0;
   endtask

   task automatic do_reset();
      v0 = 0; v1 = 0; rdy = 0; start = 0;
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_model();
   endtask

   task automatic start_cmd(input int beats, input int pkts);
      cfg_beats = LEN_W'(beats);
      cfg_pkts  = CNT_W'(pkts);
      exp_beats = beats;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // mode 0: inputs held, 1: m_tready pattern 1,0,0,1, 2: random valids/ready
   task automatic run_to_done(input int budget, input int mode);
      int k;
      k = 0;
      while (done_count == 0 && k < budget) begin
         if (mode == 1) begin
            rdy = ((k % 4) == 0) || ((k % 4) == 3);
         end else if (mode == 2) begin
            rdy = ($urandom_range(0, 3) != 0);
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
         end
         step();
         k++;
      end
      chk("done_seen", done_count, 1);
      chk("busy_at_done", {63'd0, o_busy}, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_tvalid"}, {63'd0, m_tvalid}, 0);
      chk({tag, "_tlast"},  {63'd0, m_tlast}, 0);
      chk({tag, "_tdata"},  m_tdata, 0);
      chk({tag, "_ready"},  {62'd0, s1_tready, s0_tready}, 0);
      chk({tag, "_busy"},   {63'd0, o_busy}, 0);
      chk({tag, "_done"},   {63'd0, o_done}, 0);
      chk({tag, "_grant"},  {63'd0, o_grant}, 0);
   endtask

   initial begin
      int reached;
      int b, n;
      rst_n = 1'b0;
      i_start = 0; i_pkt_beats = '0; i_num_pkts = '0;
      s0_tdata = '1; s1_tdata = '1; s0_tvalid = 1; s1_tvalid = 1; m_tready = 1;
      cfg_beats = '0; cfg_pkts = '0; exp_beats = 1;
      clear_model();
      #2;
      check_reset_outputs("por");

      // single source, 4 beats x 2 packets, cycle-exact table
      tv[0] = '{1,0,1,1, 0,0,0,0,0,0,0};
      tv[1] = '{1,0,1,0, 0,0,0,0,1,0,0};
      for (int i = 2; i <= 10; i++) begin
         if (i == 6) tv[i] = '{1,0,1,0, 0,0,0,0,1,0,0};
         else        tv[i] = '{1,0,1,0, 1,((i == 5) || (i == 10)),1,0,1,0,0};
      end
      tv[11] = '{1,0,1,0, 0,0,0,0,0,1,0};
      tv[12] = '{1,0,1,0, 0,0,0,0,0,0,0};
      do_reset();
      cfg_beats = 4; cfg_pkts = 2; exp_beats = 4;
      for (int i = 0; i < 13; i++) begin
         v0 = tv[i].v0; v1 = tv[i].v1; rdy = tv[i].rdy; start = tv[i].start;
         step();
         chk("t_tvalid", {63'd0, m_tvalid},  {63'd0, tv[i].tvalid});
         chk("t_tlast",  {63'd0, m_tlast},   {63'd0, tv[i].tlast});
         chk("t_s0r",    {63'd0, s0_tready}, {63'd0, tv[i].s0r});
         chk("t_s1r",    {63'd0, s1_tready}, {63'd0, tv[i].s1r});
         chk("t_busy",   {63'd0, o_busy},    {63'd0, tv[i].busy});
         chk("t_done",   {63'd0, o_done},    {63'd0, tv[i].done});
         chk("t_grant",  {63'd0, o_grant},   {63'd0, tv[i].grant});
      end
      start = 0;
      chk("single_beats", beats_total, 8);

      // round robin with both sources valid
      do_reset();
      alt_mode = 1; v0 = 1; v1 = 1; rdy = 1;
      start_cmd(3, 4);
      run_to_done(200, 0);
      chk("rr_pkts", pkt_src.size(), 4);
      chk("rr_beats", beats_total, 12);

      // downstream backpressure
      do_reset();
      v0 = 1; rdy = 1;
      start_cmd(5, 2);
      run_to_done(400, 1);
      chk("bp_beats", beats_total, 10);

      // granted s1 stalls mid-packet while s0 waits
      do_reset();
      alt_mode = 1; v0 = 1; v1 = 1; rdy = 1;
      start_cmd(4, 3);
      reached = 0;
      for (int k = 0; k < 100 && reached == 0; k++) begin
         step();
         if (pkt_src.size() == 2 && beat_in_pkt == 2) reached = 1;
      end
      chk("stall_reached", reached, 1);
      v1 = 0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("stall_grant", {63'd0, o_grant}, 1);
         chk("stall_s0r", {63'd0, s0_tready}, 0);
         chk("stall_tvalid", {63'd0, m_tvalid}, 0);
      end
      v1 = 1;
      run_to_done(200, 0);
      chk("stall_pkts", pkt_src.size(), 3);
      chk("stall_beats", beats_total, 12);

      // zero configuration pulses done without going busy
      for (int z = 0; z < 2; z++) begin
         do_reset();
         start_cmd((z == 0) ? 4 : 0, (z == 0) ? 0 : 3);
         step();
         chk("zero_done", {63'd0, o_done}, 1);
         chk("zero_busy", {63'd0, o_busy}, 0);
         step();
         chk("zero_done_clr", {63'd0, o_done}, 0);
         chk("zero_busy2", {63'd0, o_busy}, 0);
      end

      // start while busy is ignored
      do_reset();
      v0 = 1; rdy = 1;
      start_cmd(3, 2);
      repeat (3) step();
      cfg_beats = 2; cfg_pkts = 5; start = 1;
      step();
      start = 0;
      run_to_done(200, 0);
      chk("busy_start_beats", beats_total, 6);
      chk("busy_start_pkts", pkt_src.size(), 2);
      repeat (3) step();
      chk("busy_start_done1", done_count, 1);
      chk("busy_start_idle", {63'd0, o_busy}, 0);

      // asynchronous reset during beat 2 of an s1 packet
      do_reset();
      alt_mode = 1; v0 = 1; v1 = 1; rdy = 1;
      start_cmd(4, 3);
      reached = 0;
      for (int k = 0; k < 100 && reached == 0; k++) begin
         step();
         if (pkt_src.size() == 2 && beat_in_pkt == 1) reached = 1;
      end
      chk("arst_reached", reached, 1);
      @(posedge clk);
      #1;
      chk("arst_pre_grant", {63'd0, o_grant}, 1);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("arst");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      beat_in_pkt = 0; pkt_src.delete(); done_count = 0; beats_total = 0;
      prev_stall = 1'b0;
      start_cmd(2, 1);
      run_to_done(100, 0);
      chk("arst_pkts", pkt_src.size(), 1);
      chk("arst_beats", beats_total, 2);

      // randomized runs
      for (int it = 0; it < 20; it++) begin
         do_reset();
         b = $urandom_range(1, 6);
         n = $urandom_range(1, 5);
         v0 = ($urandom_range(0, 1) != 0);
         v1 = ($urandom_range(0, 1) != 0);
         rdy = 1;
         start_cmd(b, n);
         run_to_done(3000, 2);
         chk("rand_beats", beats_total, b * n);
         chk("rand_pkts", pkt_src.size(), n);
         step();
         chk("rand_single_done", done_count, 1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/out_stream_scheduler.md
# out_stream_scheduler

Packet-level scheduler that shares the single 64-bit AXI-Stream output port to the DMA S2MM channel between two output-buffer streams, for example ping-pong PPU output banks. It grants one source at a time in round-robin order and holds the grant for a whole packet. It counts beats, generates TLAST at the configured packet length, and pulses done after the configured number of packets.

## Interface
- DATA_W, 64, stream data width
- LEN_W, 16, width of beats-per-packet config and beat counter
- CNT_W, 12, width of packet-count config and packet counter
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_start  in  1  one-cycle start pulse; latches config
- i_pkt_beats  in  LEN_W  beats per packet (e.g. 2×M for M rows of 128-bit)
- i_num_pkts  in  CNT_W  total packets to forward, summed over both sources
- s0_tdata / s1_tdata  in  DATA_W  source data
- s0_tvalid / s1_tvalid  in  1  source valid
- s0_tready / s1_tready  out  1  source ready
- m_tdata  out  DATA_W  to DMA
- m_tvalid  out  1  to DMA
- m_tready  in  1  from DMA
- m_tlast  out  1  last beat of packet
- o_busy  out  1  high from the cycle after i_start until done
- o_done  out  1  one-cycle pulse when the final packet completes
- o_grant  out  1  currently or last granted source (0/1)

## Operation
- **States:** IDLE, ARB, XFER.
- **IDLE:**
  - On i_start, latch i_pkt_beats and i_num_pkts, clear both counters, go to ARB.
  - If i_start arrives with either config value zero, pulse o_done next cycle and stay in IDLE.
- **ARB:**
  - If no source tvalid, wait.
  - If exactly one source is valid, grant it.
  - If both are valid, grant the source that is not rr_last. rr_last resets to 1, so source 0 wins first.
  - Register the grant and go to XFER.
- **XFER:**
  - Combinational pass-through: m_tdata/m_tvalid come from the granted source, granted tready = m_tready, ungranted tready = 0.
  - Each handshake (m_tvalid & m_tready) increments beat_cnt.
  - m_tlast = m_tvalid & (beat_cnt == pkt_beats−1).
- **Last-beat handshake:**
  - Clear beat_cnt, set rr_last = grant, increment pkt_cnt.
  - If pkt_cnt == num_pkts−1, go to IDLE with an o_done pulse; otherwise go to ARB.
- **Grant lock:** a granted source keeps the grant for its whole packet, even if its tvalid drops mid-packet. Nothing is reordered.
- **i_start while busy:** ignored, config unchanged.
- **Outside XFER:** m_tvalid = 0 and both tready = 0.
- **Counters:** beat_cnt is LEN_W bits and pkt_cnt is CNT_W bits. Comparisons use the latched values, so no wrap-around occurs within legal config.

## Timing
- **Reset values:** state IDLE, m_tvalid 0, m_tlast 0, m_tdata 0 (mux selects source 0 data but gated by tvalid 0), s0_tready/s1_tready 0, o_busy 0, o_done 0, o_grant 0, counters 0.
- **Start latency:** i_start at cycle T → ARB at T+1. With a source valid at T+1, first handshake possible at T+2.
- **Inter-packet gap:** exactly one ARB cycle between packets (max throughput pkt_beats/(pkt_beats+1)).
- **Done timing:** o_done is asserted in the cycle after the final handshake. o_busy falls in the same cycle.
- **Stream data path:** zero latency, not registered. Downstream stalls (m_tready = 0) hold beat_cnt and m_tlast stable.
- **Mid-operation reset:** returns to reset values immediately and asynchronously. Partial packets are lost and no o_done is produced.

## Structure
- **Shared package / header `out_sched_pkg`:**
  - state encodings (IDLE = 0, ARB = 1, XFER = 2)
  - source IDs SRC0 = 0, SRC1 = 1
  - default LEN_W/CNT_W
- **Sub-module `out_rr_arb2`:**
  - 2-way round-robin grant from valid bits and the rr_last pointer
  - pointer update on a packet-done strobe
- **Top level:** FSM, counters and the stream mux.

## Test plan
- **Single source:** reset, start with pkt_beats=4, num_pkts=2, only s0 valid continuously, m_tready=1. Expect 8 beats with m_tlast on beats 4 and 8, one gap cycle between packets, o_done one cycle after beat 8, s1_tready held 0.
- **Round-robin:** both sources valid, pkt_beats=3, num_pkts=4. Expect packet order s0, s1, s0, s1 with o_grant matching, and no beat interleaving within a packet.
- **Backpressure:** m_tready toggles 1,0,0,1,… with pkt_beats=5. Expect data and m_tlast stable during stalls, m_tlast only on handshake 5, no beats dropped or duplicated (data ramp check).
- **Source stall:** granted s1 drops tvalid for 3 cycles mid-packet while s0 is valid. Expect the grant to stay on s1, s0_tready 0, the packet to complete from s1, then s0 served.
- **Zero config and busy start:** start with num_pkts=0 → o_done next cycle, o_busy stays 0. A second i_start during XFER is ignored and the original count completes.
- **Async reset mid-packet:** assert rst_n low during beat 2 of 4. Expect all outputs at reset values immediately. After release, a new start runs cleanly from source 0.
